// File: rtl/counter_cmd_sequencer.sv
// Command sequencer: FIFO-buffered commands expanded into one-hot counter strobes.
// Optional `SEQ_ABORT_EN adds an Abort input that flushes the FIFO and executor.
module counter_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 4
) (
  input  logic             Clock,
  input  logic             ResetN,
`ifdef SEQ_ABORT_EN
  input  logic             Abort,
`endif
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [2:0]       CmdOp,
  input  logic [CNT_W-1:0] CmdCount,
  input  logic [7:0]       CmdData,
  output logic             DoReset,
  output logic             DoIncrement,
  output logic             DoDecrement,
  output logic             DoShiftL2R,
  output logic             DoShiftR2L,
  output logic             CounterInMSB,
  output logic             CounterInLSB,
  output logic             Busy,
  output logic             CmdError
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 3 + CNT_W + 8;
  localparam int RW = CNT_W + 1;

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   OCC_ONE = 1;
  localparam logic [AW:0]   OCC_FULL = FIFO_DEPTH;
  localparam logic [RW-1:0] REM_ONE = 1;

  localparam logic [2:0] OP_CLR = 3'd0;
  localparam logic [2:0] OP_INC = 3'd1;
  localparam logic [2:0] OP_DEC = 3'd2;
  localparam logic [2:0] OP_L2R = 3'd3;
  localparam logic [2:0] OP_R2L = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ERR
  } state_e;

  logic abort;
`ifdef SEQ_ABORT_EN
  assign abort = Abort;
`else
  assign abort = 1'b0;
`endif

  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      occ_q, occ_d;
  logic             full, empty;
  logic             push, pop;

  logic [EW-1:0]    head;
  logic [2:0]       head_op;
  logic [CNT_W-1:0] head_cnt;
  logic [7:0]       head_data;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [7:0]       data_q, data_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [2:0]       k_q, k_d;

  logic [4:0]       strb_q, strb_d;
  logic             msb_q, msb_d;
  logic             lsb_q, lsb_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  assign full     = (occ_q == OCC_FULL);
  assign empty    = (occ_q == '0);
  assign CmdReady = ResetN && !full && !abort;
  assign push     = CmdValid && CmdReady;

  assign head      = mem_q[rd_q];
  assign head_op   = head[EW-1 -: 3];
  assign head_cnt  = head[8 +: CNT_W];
  assign head_data = head[7:0];

  // FIFO storage; contents need no reset since pointers gate them
  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_q] <= {CmdOp, CmdCount, CmdData};
  end

  // FIFO pointer and occupancy next state
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (push) wr_d = wr_q + PTR_ONE;
    if (pop)  rd_d = rd_q + PTR_ONE;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
    if (abort) begin
      wr_d  = '0;
      rd_d  = '0;
      occ_d = '0;
    end
  end

  // Executor next state; the head pops on the edge ending the last step
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    k_d     = k_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: pop = !empty;
      S_RUN: begin
        if (rem_q == REM_ONE) begin
          pop     = !empty;
          state_d = S_IDLE;
        end else begin
          rem_d = rem_q - REM_ONE;
          k_d   = k_q + 3'd1;
        end
      end
      S_ERR: begin
        pop     = !empty;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) pop = 1'b0;
    if (pop) begin
      if (head_op > OP_R2L) begin
        state_d = S_ERR;
      end else begin
        state_d = S_RUN;
        op_d    = head_op;
        data_d  = head_data;
        rem_d   = {1'b0, head_cnt} + REM_ONE;
        k_d     = '0;
      end
    end
    if (abort) state_d = S_IDLE;
  end

  // Registered outputs decoded from the next executor state
  always_comb begin
    strb_d = '0;
    msb_d  = 1'b0;
    lsb_d  = 1'b0;
    err_d  = (state_d == S_ERR);
    busy_d = (occ_d != '0) || (state_d != S_IDLE);
    if (state_d == S_RUN) begin
      unique case (op_d)
        OP_CLR: strb_d[0] = 1'b1;
        OP_INC: strb_d[1] = 1'b1;
        OP_DEC: strb_d[2] = 1'b1;
        OP_L2R: begin
          strb_d[3] = 1'b1;
          msb_d     = data_d[k_d];
        end
        OP_R2L: begin
          strb_d[4] = 1'b1;
          lsb_d     = data_d[3'd7 - k_d];
        end
        default: strb_d = '0;
      endcase
    end
  end

  // State, pointer and output registers
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      state_q <= S_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      k_q     <= '0;
      strb_q  <= '0;
      msb_q   <= 1'b0;
      lsb_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      k_q     <= k_d;
      strb_q  <= strb_d;
      msb_q   <= msb_d;
      lsb_q   <= lsb_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign DoReset      = strb_q[0];
  assign DoIncrement  = strb_q[1];
  assign DoDecrement  = strb_q[2];
  assign DoShiftL2R   = strb_q[3];
  assign DoShiftR2L   = strb_q[4];
  assign CounterInMSB = msb_q;
  assign CounterInLSB = lsb_q;
  assign CmdError     = err_q;
  assign Busy         = busy_q;

endmodule
